// File: rtl/uart_tx_sched_if.sv
// Requester/UART-TX handshake bundle for uart_tx_sched.
// The scheduler connects through the slave modport; the requesters and UART side use master.
interface uart_tx_sched_if;
    logic       REQ0_VALID;
    logic [7:0] REQ0_DATA;
    logic       REQ0_PAR_EN;
    logic       REQ0_PAR_TYP;
    logic       REQ0_READY;
    logic       REQ1_VALID;
    logic [7:0] REQ1_DATA;
    logic       REQ1_PAR_EN;
    logic       REQ1_PAR_TYP;
    logic       REQ1_READY;
    logic       DATA_VALID;
    logic [7:0] P_DATA;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic       Busy;
    logic       GRANT_ID;
    logic       ERR;

    modport slave (
        input  REQ0_VALID, REQ0_DATA, REQ0_PAR_EN, REQ0_PAR_TYP,
        input  REQ1_VALID, REQ1_DATA, REQ1_PAR_EN, REQ1_PAR_TYP,
        input  Busy,
        output REQ0_READY, REQ1_READY,
        output DATA_VALID, P_DATA, PAR_EN, PAR_TYP, GRANT_ID, ERR
    );

    modport master (
        output REQ0_VALID, REQ0_DATA, REQ0_PAR_EN, REQ0_PAR_TYP,
        output REQ1_VALID, REQ1_DATA, REQ1_PAR_EN, REQ1_PAR_TYP,
        output Busy,
        input  REQ0_READY, REQ1_READY,
        input  DATA_VALID, P_DATA, PAR_EN, PAR_TYP, GRANT_ID, ERR
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin scheduler feeding one UART TX, with a Busy-rise watchdog.
// state       | meaning
// S_IDLE      | arbitrate when Busy=0; READY is combinational for the winner
// S_ISSUE     | one-cycle DATA_VALID pulse with the latched byte/parity
// S_WAIT_BUSY | wait up to WAIT_MAX cycles for Busy; give up with sticky ERR
// S_SENDING   | UART transmitting; return to IDLE when Busy falls
module uart_tx_sched #(
    parameter int WAIT_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_sched_if.slave io_bus
);
    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_SENDING
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_last_grant;
    logic          r_grant_id;
    logic          r_data_valid;
    logic [7:0]    r_p_data;
    logic          r_par_en;
    logic          r_par_typ;
    logic          r_err;

    logic w_idle_free;
    logic w_gnt0;
    logic w_gnt1;

    // On a tie the requester that did not win last time goes first.
    assign w_idle_free = (r_state == S_IDLE) && !io_bus.Busy;
    assign w_gnt0 = w_idle_free && io_bus.REQ0_VALID && (!io_bus.REQ1_VALID || r_last_grant);
    assign w_gnt1 = w_idle_free && io_bus.REQ1_VALID && (!io_bus.REQ0_VALID || !r_last_grant);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            r_grant_id   <= 1'b0;
            r_data_valid <= 1'b0;
            r_p_data     <= 8'h00;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_data_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        r_p_data     <= w_gnt1 ? io_bus.REQ1_DATA    : io_bus.REQ0_DATA;
                        r_par_en     <= w_gnt1 ? io_bus.REQ1_PAR_EN  : io_bus.REQ0_PAR_EN;
                        r_par_typ    <= w_gnt1 ? io_bus.REQ1_PAR_TYP : io_bus.REQ0_PAR_TYP;
                        r_grant_id   <= w_gnt1;
                        r_data_valid <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (io_bus.Busy) begin
                        r_state <= S_SENDING;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err        <= 1'b1;
                        r_last_grant <= r_grant_id;
                        r_state      <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SENDING: begin
                    if (!io_bus.Busy) begin
                        r_last_grant <= r_grant_id;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.REQ0_READY = w_gnt0;
    assign io_bus.REQ1_READY = w_gnt1;
    assign io_bus.DATA_VALID = r_data_valid;
    assign io_bus.P_DATA     = r_p_data;
    assign io_bus.PAR_EN     = r_par_en;
    assign io_bus.PAR_TYP    = r_par_typ;
    assign io_bus.GRANT_ID   = r_grant_id;
    assign io_bus.ERR        = r_err;
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed self-checking bench for uart_tx_sched (WAIT_MAX = 4).
module tb_uart_tx_sched;
    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    uart_tx_sched_if bus();

    uart_tx_sched #(.WAIT_MAX(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    // One full transfer from IDLE with Busy rising one cycle after DATA_VALID for 10 cycles.
    task automatic xfer(input logic id, input logic [7:0] d);
        #1;
        chk1("xfer_rdy0", bus.REQ0_READY, !id);
        chk1("xfer_rdy1", bus.REQ1_READY, id);
        tick();
        chk1("xfer_dv", bus.DATA_VALID, 1'b1);
        chk1("xfer_gid", bus.GRANT_ID, id);
        chk8("xfer_pdata", bus.P_DATA, d);
        tick();
        chk1("xfer_dv_once", bus.DATA_VALID, 1'b0);
        bus.Busy = 1'b1;
        tick();
        chk1("xfer_rdy_sending", bus.REQ0_READY | bus.REQ1_READY, 1'b0);
        repeat (9) tick();
        bus.Busy = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        bus.REQ0_VALID = 1'b0; bus.REQ0_DATA = 8'h00; bus.REQ0_PAR_EN = 1'b0; bus.REQ0_PAR_TYP = 1'b0;
        bus.REQ1_VALID = 1'b0; bus.REQ1_DATA = 8'h00; bus.REQ1_PAR_EN = 1'b0; bus.REQ1_PAR_TYP = 1'b0;
        bus.Busy = 1'b0;
        repeat (2) tick();
        chk8("rst_pdata", bus.P_DATA, 8'h00);
        chk1("rst_dv", bus.DATA_VALID, 1'b0);
        chk1("rst_err", bus.ERR, 1'b0);
        chk1("rst_gid", bus.GRANT_ID, 1'b0);
        chk1("rst_rdy0", bus.REQ0_READY, 1'b0);
        reset = 1'b1;

        // Single request, granted on the first edge after reset release
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'hA5; bus.REQ0_PAR_EN = 1'b1; bus.REQ0_PAR_TYP = 1'b1;
        #1;
        chk1("single_rdy0", bus.REQ0_READY, 1'b1);
        chk1("single_rdy1", bus.REQ1_READY, 1'b0);
        tick();
        bus.REQ0_VALID = 1'b0;
        chk1("single_dv", bus.DATA_VALID, 1'b1);
        chk8("single_pdata", bus.P_DATA, 8'hA5);
        chk1("single_paren", bus.PAR_EN, 1'b1);
        chk1("single_partyp", bus.PAR_TYP, 1'b1);
        chk1("single_gid", bus.GRANT_ID, 1'b0);
        tick();
        chk1("single_dv_low", bus.DATA_VALID, 1'b0);
        bus.Busy = 1'b1;
        tick();
        bus.Busy = 1'b0;
        tick();

        // Contention: round robin starting with requester 0
        do_reset();
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'h11; bus.REQ0_PAR_EN = 1'b0; bus.REQ0_PAR_TYP = 1'b0;
        bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = 8'h22;
        xfer(1'b0, 8'h11);
        xfer(1'b1, 8'h22);
        xfer(1'b0, 8'h11);
        xfer(1'b1, 8'h22);
        chk1("contention_err", bus.ERR, 1'b0);

        // Busy held high in IDLE blocks all grants
        do_reset();
        bus.Busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk1("busy_idle_rdy", bus.REQ0_READY | bus.REQ1_READY, 1'b0);
            chk1("busy_idle_dv", bus.DATA_VALID, 1'b0);
            tick();
        end
        bus.Busy = 1'b0;
        xfer(1'b0, 8'h11);

        // Timeout: Busy never rises
        do_reset();
        bus.REQ1_VALID = 1'b0;
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'h5A;
        #1;
        chk1("to_rdy0", bus.REQ0_READY, 1'b1);
        tick();
        bus.REQ0_VALID = 1'b0;
        chk1("to_dv", bus.DATA_VALID, 1'b1);
        chk8("to_pdata", bus.P_DATA, 8'h5A);
        repeat (4) tick();
        bus.REQ1_VALID = 1'b1; bus.REQ1_DATA = 8'h3C; bus.REQ1_PAR_EN = 1'b1; bus.REQ1_PAR_TYP = 1'b0;
        #1;
        chk1("to_still_waiting", bus.REQ1_READY, 1'b0);
        chk1("to_err_early", bus.ERR, 1'b0);
        tick();
        chk1("to_err_set", bus.ERR, 1'b1);
        chk1("to_back_idle", bus.REQ1_READY, 1'b1);
        tick();
        bus.REQ1_VALID = 1'b0;
        chk1("to_next_dv", bus.DATA_VALID, 1'b1);
        chk1("to_next_gid", bus.GRANT_ID, 1'b1);
        chk8("to_next_pdata", bus.P_DATA, 8'h3C);
        tick();
        bus.Busy = 1'b1;
        tick();
        chk1("to_err_sticky", bus.ERR, 1'b1);
        chk8("mid_pdata_before", bus.P_DATA, 8'h3C);

        // Reset in SENDING
        reset = 1'b0;
        #1;
        chk8("mid_pdata", bus.P_DATA, 8'h00);
        chk1("mid_err", bus.ERR, 1'b0);
        chk1("mid_gid", bus.GRANT_ID, 1'b0);
        chk1("mid_paren", bus.PAR_EN, 1'b0);
        chk1("mid_dv", bus.DATA_VALID, 1'b0);
        reset = 1'b1;
        bus.Busy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk1("mid_no_dv", bus.DATA_VALID, 1'b0);
        end

        // Latched outputs stay put while requester inputs wiggle
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'hC3; bus.REQ0_PAR_EN = 1'b1; bus.REQ0_PAR_TYP = 1'b0;
        #1;
        chk1("stab_rdy0", bus.REQ0_READY, 1'b1);
        tick();
        chk1("stab_dv", bus.DATA_VALID, 1'b1);
        tick();
        bus.Busy = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.REQ0_DATA    = 8'(i * 37 + 1);
            bus.REQ0_PAR_EN  = i[0];
            bus.REQ0_PAR_TYP = ~i[0];
            tick();
            chk8("stab_pdata", bus.P_DATA, 8'hC3);
            chk1("stab_paren", bus.PAR_EN, 1'b1);
            chk1("stab_partyp", bus.PAR_TYP, 1'b0);
            chk1("stab_rdy0_low", bus.REQ0_READY, 1'b0);
        end
        bus.REQ0_VALID = 1'b0;
        bus.Busy = 1'b0;
        tick();
        chk8("stab_hold_idle", bus.P_DATA, 8'hC3);
        bus.REQ0_VALID = 1'b1; bus.REQ0_DATA = 8'h77;
        #1;
        chk1("stab_regrant", bus.REQ0_READY, 1'b1);
        tick();
        bus.REQ0_VALID = 1'b0;
        chk8("stab_new_pdata", bus.P_DATA, 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
